// File: rtl/litspin_gs_pkg.sv
// Shared grayscale-path types and default frame geometry.
// Holds the sequencer state encoding and a safe clog2 helper.
package litspin_gs_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SHIFT_HI = 3'd1,
      SHIFT_LO = 3'd2,
      LATCH    = 3'd3,
      DONE     = 3'd4
   } gs_state_e;

   localparam int GS_NB_BITS = 10;
   localparam int GS_NB_ROWS = 4;
   localparam int GS_WORDS   = GS_NB_BITS * GS_NB_ROWS;

   // clog2 that never yields a zero-width vector
   function automatic int clog2_min1(input int v);
      return ($clog2(v) < 1) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/sclk_phase_timer.sv
// Loadable down-counter timing one SCLK/LAT phase.
// Ports: clk, rst, load_i/load_val_i (phase length-1), expire_o.
module sclk_phase_timer
#(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         expire_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // strobe during the last cycle of the phase
   assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/gs_shift_sequencer.sv
// Grayscale shift/latch sequencer: one frame of SCLK words per angle.
// Ports: clk, rst, angle, FC_en, ovr_clr -> SCLK, LAT, busy, frame_done, overrun.
module gs_shift_sequencer
   import litspin_gs_pkg::*;
#(
   parameter int NB_ANGLES         = 128,
   parameter int NB_LEDS_PER_GROUP = 16,
   parameter int NB_BITS           = GS_NB_BITS,
   parameter int NB_ROWS           = GS_NB_ROWS,
   parameter int SCLK_HALF         = 2,
   parameter int LAT_CYCLES        = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [$clog2(NB_ANGLES)-1:0] angle,
   input  logic                         FC_en,
   input  logic                         ovr_clr,
   output logic                         SCLK,
   output logic                         LAT,
   output logic                         busy,
   output logic                         frame_done,
   output logic                         overrun
);

   localparam int PULSES = 3 * NB_LEDS_PER_GROUP;
   localparam int WORDS  = NB_BITS * NB_ROWS;
   localparam int PW     = clog2_min1(PULSES);
   localparam int WW     = clog2_min1(WORDS);
   localparam int TMAX   = (SCLK_HALF > LAT_CYCLES) ?
                           SCLK_HALF : LAT_CYCLES;
   localparam int TW     = clog2_min1(TMAX);

   localparam logic [PW-1:0] PULSE_LAST = PW'(PULSES - 1);
   localparam logic [WW-1:0] WORD_LAST  = WW'(WORDS - 1);
   localparam logic [TW-1:0] T_SCLK     = TW'(SCLK_HALF - 1);
   localparam logic [TW-1:0] T_LAT      = TW'(LAT_CYCLES - 1);

   logic [$clog2(NB_ANGLES)-1:0] angle_q;
   gs_state_e                    state_q, state_d;
   logic [PW-1:0]                pulse_q, pulse_d;
   logic [WW-1:0]                word_q, word_d;
   logic                         sclk_q, lat_q, busy_q;
   logic                         done_q, ovr_q;
   logic                         new_angle, busy_st;
   logic                         ovr_set, t_load, t_exp;
   logic [TW-1:0]                t_val;

   assign new_angle = (angle != angle_q);
   assign busy_st   = (state_q == SHIFT_HI) ||
                      (state_q == SHIFT_LO) ||
                      (state_q == LATCH);

   sclk_phase_timer #(
      .W (TW)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (t_load),
      .load_val_i (t_val),
      .expire_o   (t_exp)
   );

   always_comb begin
      state_d = state_q;
      pulse_d = pulse_q;
      word_d  = word_q;
      ovr_set = 1'b0;
      t_load  = 1'b0;
      t_val   = T_SCLK;
      if (FC_en) begin
         state_d = IDLE;
         pulse_d = '0;
         word_d  = '0;
      end else if (new_angle && busy_st) begin
         // restart the frame for the new angle
         ovr_set = 1'b1;
         state_d = SHIFT_HI;
         pulse_d = '0;
         word_d  = '0;
         t_load  = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (new_angle) begin
                  state_d = SHIFT_HI;
                  t_load  = 1'b1;
               end
            end
            SHIFT_HI: begin
               if (t_exp) begin
                  state_d = SHIFT_LO;
                  t_load  = 1'b1;
               end
            end
            SHIFT_LO: begin
               if (t_exp) begin
                  t_load = 1'b1;
                  if (pulse_q == PULSE_LAST) begin
                     pulse_d = '0;
                     state_d = LATCH;
                     t_val   = T_LAT;
                  end else begin
                     pulse_d = pulse_q + PW'(1);
                     state_d = SHIFT_HI;
                  end
               end
            end
            LATCH: begin
               if (t_exp) begin
                  if (word_q == WORD_LAST) begin
                     word_d  = '0;
                     state_d = DONE;
                  end else begin
                     word_d  = word_q + WW'(1);
                     state_d = SHIFT_HI;
                     t_load  = 1'b1;
                  end
               end
            end
            DONE: begin
               // back-to-back frame is not an overrun
               if (new_angle) begin
                  state_d = SHIFT_HI;
                  t_load  = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // previous angle tracks even in reset
      angle_q <= angle;
      if (rst) begin
         state_q <= IDLE;
         pulse_q <= '0;
         word_q  <= '0;
         sclk_q  <= 1'b0;
         lat_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pulse_q <= pulse_d;
         word_q  <= word_d;
         sclk_q  <= (state_d == SHIFT_HI);
         lat_q   <= (state_d == LATCH);
         busy_q  <= (state_d == SHIFT_HI) ||
                    (state_d == SHIFT_LO) ||
                    (state_d == LATCH);
         done_q  <= (state_d == DONE);
         if (ovr_set)      ovr_q <= 1'b1;
         else if (ovr_clr) ovr_q <= 1'b0;
      end
   end

   assign SCLK       = sclk_q;
   assign LAT        = lat_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_gs_shift_sequencer.sv
// Directed bench for gs_shift_sequencer.
// Default instance plus a short-frame instance.
module tb_gs_shift_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] angle_a = '0;
   logic [6:0] angle_b = '0;
   logic       fc = 1'b0;
   logic       clr = 1'b0;
   logic       sclk_a, lat_a, busy_a, fd_a, ovr_a;
   logic       sclk_b, lat_b, busy_b, fd_b, ovr_b;

   int n_chk = 0, n_pass = 0, n_fail = 0;
   int cyc = 0;
   int n_sclk_a = 0, n_lat_a = 0, n_latc_a = 0;
   int n_busy_a = 0, n_fd_a = 0, fd_cyc_a = 0;
   int n_sclk_b = 0, n_lat_b = 0, n_latc_b = 0;
   int n_busy_b = 0, n_fd_b = 0, fd_cyc_b = 0;
   logic sp_a = 1'b0, lp_a = 1'b0;
   logic sp_b = 1'b0, lp_b = 1'b0;

   always #5 clk = ~clk;

   gs_shift_sequencer u_a (
      .clk        (clk),
      .rst        (rst),
      .angle      (angle_a),
      .FC_en      (fc),
      .ovr_clr    (clr),
      .SCLK       (sclk_a),
      .LAT        (lat_a),
      .busy       (busy_a),
      .frame_done (fd_a),
      .overrun    (ovr_a)
   );

   gs_shift_sequencer #(
      .SCLK_HALF  (1),
      .LAT_CYCLES (1),
      .NB_ROWS    (1)
   ) u_b (
      .clk        (clk),
      .rst        (rst),
      .angle      (angle_b),
      .FC_en      (1'b0),
      .ovr_clr    (1'b0),
      .SCLK       (sclk_b),
      .LAT        (lat_b),
      .busy       (busy_b),
      .frame_done (fd_b),
      .overrun    (ovr_b)
   );

   // output monitors, sampled 1 time unit after each edge
   always @(posedge clk) begin
      #1;
      cyc++;
      if (sclk_a && !sp_a) n_sclk_a++;
      if (lat_a && !lp_a) n_lat_a++;
      if (lat_a) n_latc_a++;
      if (busy_a) n_busy_a++;
      if (fd_a) begin n_fd_a++; fd_cyc_a = cyc; end
      sp_a = sclk_a;
      lp_a = lat_a;
      if (sclk_b && !sp_b) n_sclk_b++;
      if (lat_b && !lp_b) n_lat_b++;
      if (lat_b) n_latc_b++;
      if (busy_b) n_busy_b++;
      if (fd_b) begin n_fd_b++; fd_cyc_b = cyc; end
      sp_b = sclk_b;
      lp_b = lat_b;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d",
                tag, obs, exp);
      end
   endtask

   task automatic wait_fd(input int f0, input int max,
                          output logic ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         step(1);
         if (n_fd_a > f0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      int s0, l0, lc0, b0, f0, t0;
      int s0b, l0b, lc0b, b0b, f0b;
      logic ok;

      // reset
      step(3);
      check("rst_sclk", 32'(sclk_a), 0);
      check("rst_lat", 32'(lat_a), 0);
      check("rst_busy", 32'(busy_a), 0);
      check("rst_fd", 32'(fd_a), 0);
      check("rst_ovr", 32'(ovr_a), 0);
      check("rst_busy_b", 32'(busy_b), 0);
      rst = 1'b0;
      step(4);
      check("no_start_after_rst", 32'(busy_a), 0);

      // full frame on both instances
      s0 = n_sclk_a; l0 = n_lat_a; lc0 = n_latc_a;
      b0 = n_busy_a; f0 = n_fd_a;
      s0b = n_sclk_b; l0b = n_lat_b; lc0b = n_latc_b;
      b0b = n_busy_b; f0b = n_fd_b;
      t0 = cyc;
      angle_a = 7'd1;
      angle_b = 7'd1;
      wait_fd(f0, 9000, ok);
      check("frame_timeout", 32'(ok), 1);
      step(2);
      check("frame_sclk", 32'(n_sclk_a - s0), 1920);
      check("frame_lat", 32'(n_lat_a - l0), 40);
      check("frame_latc", 32'(n_latc_a - lc0), 80);
      check("frame_busy", 32'(n_busy_a - b0), 7760);
      check("frame_fd", 32'(n_fd_a - f0), 1);
      check("frame_fd_time", 32'(fd_cyc_a - t0), 7761);
      check("frame_ovr", 32'(ovr_a), 0);
      check("b_sclk", 32'(n_sclk_b - s0b), 480);
      check("b_lat", 32'(n_lat_b - l0b), 10);
      check("b_latc", 32'(n_latc_b - lc0b), 10);
      check("b_busy", 32'(n_busy_b - b0b), 970);
      check("b_fd", 32'(n_fd_b - f0b), 1);
      check("b_fd_time", 32'(fd_cyc_b - t0), 971);
      check("b_ovr", 32'(ovr_b), 0);

      // overrun at word 10 latch
      f0 = n_fd_a; l0 = n_lat_a;
      angle_a = 7'd2;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         step(1);
         if (n_lat_a - l0 == 11) begin
            ok = 1'b1;
            break;
         end
      end
      check("w10_timeout", 32'(ok), 1);
      check("w10_in_latch", 32'(lat_a), 1);
      s0 = n_sclk_a; l0 = n_lat_a; t0 = cyc;
      angle_a = 7'd3;
      step(1);
      check("ovr_set", 32'(ovr_a), 1);
      check("restart_sclk", 32'(sclk_a), 1);
      check("restart_lat", 32'(lat_a), 0);
      wait_fd(f0, 9000, ok);
      check("restart_timeout", 32'(ok), 1);
      step(2);
      check("restart_pulses", 32'(n_sclk_a - s0), 1920);
      check("restart_lat_n", 32'(n_lat_a - l0), 40);
      check("restart_fd_n", 32'(n_fd_a - f0), 1);
      check("restart_fd_time", 32'(fd_cyc_a - t0), 7761);
      check("ovr_sticky", 32'(ovr_a), 1);

      // clear versus set
      clr = 1'b1;
      step(1);
      check("clr_alone", 32'(ovr_a), 0);
      clr = 1'b0;
      angle_a = 7'd4;
      step(10);
      check("busy_mid", 32'(busy_a), 1);
      angle_a = 7'd5;
      clr = 1'b1;
      step(1);
      check("set_beats_clr", 32'(ovr_a), 1);
      step(1);
      check("clr_next", 32'(ovr_a), 0);
      clr = 1'b0;

      // FC_en mid word, angle changes ignored
      step(20);
      f0 = n_fd_a;
      fc = 1'b1;
      step(1);
      check("fc_sclk", 32'(sclk_a), 0);
      check("fc_busy", 32'(busy_a), 0);
      check("fc_lat", 32'(lat_a), 0);
      angle_a = 7'd6;
      step(2);
      angle_a = 7'd7;
      step(2);
      check("fc_hold_busy", 32'(busy_a), 0);
      fc = 1'b0;
      step(100);
      check("fc_no_frame", 32'(busy_a), 0);
      check("fc_no_fd", 32'(n_fd_a - f0), 0);
      check("fc_no_ovr", 32'(ovr_a), 0);

      // reset while latching
      angle_a = 7'd8;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         step(1);
         if (lat_a) begin
            ok = 1'b1;
            break;
         end
      end
      check("latch_timeout", 32'(ok), 1);
      f0 = n_fd_a;
      rst = 1'b1;
      step(1);
      check("rl_sclk", 32'(sclk_a), 0);
      check("rl_lat", 32'(lat_a), 0);
      check("rl_busy", 32'(busy_a), 0);
      check("rl_fd", 32'(fd_a), 0);
      check("rl_ovr", 32'(ovr_a), 0);
      step(1);
      rst = 1'b0;
      step(20);
      check("rl_no_start", 32'(busy_a), 0);
      check("rl_no_fd", 32'(n_fd_a - f0), 0);

      // new angle in DONE chains without overrun
      f0 = n_fd_a;
      angle_a = 7'd9;
      wait_fd(f0, 9000, ok);
      check("done_timeout", 32'(ok), 1);
      check("in_done", 32'(fd_a), 1);
      f0 = n_fd_a; s0 = n_sclk_a;
      angle_a = 7'd10;
      step(1);
      check("chain_busy", 32'(busy_a), 1);
      check("chain_sclk", 32'(sclk_a), 1);
      check("chain_fd_low", 32'(fd_a), 0);
      check("chain_ovr", 32'(ovr_a), 0);
      wait_fd(f0, 9000, ok);
      check("chain_timeout", 32'(ok), 1);
      check("chain_pulses", 32'(n_sclk_a - s0), 1920);
      check("chain_ovr_end", 32'(ovr_a), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/gs_shift_sequencer.md
GS_SHIFT_SEQUENCER -- requirements
Module: gs_shift_sequencer

Interface
REQ-001 SHALL have parameter NB_ANGLES, default 128, number of angular positions per revolution.
REQ-002 SHALL have parameter NB_LEDS_PER_GROUP, default 16, LEDs per multiplexing group; power of 2.
REQ-003 SHALL have parameter NB_BITS, default 10, grayscale bit planes per row.
REQ-004 SHALL have parameter NB_ROWS, default 4, multiplexed rows per angle.
REQ-005 SHALL have parameter SCLK_HALF, default 2, SCLK half-period in clk cycles; range >=1.
REQ-006 SHALL have parameter LAT_CYCLES, default 2, LAT pulse width in clk cycles; range >=1.
REQ-007 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port angle, input, $clog2(NB_ANGLES) bits: current angular position.
REQ-010 SHALL have port FC_en, input, 1 bit: function-control write in progress; the GS path is blocked while high.
REQ-011 SHALL have port ovr_clr, input, 1 bit: clears the overrun flag.
REQ-012 SHALL have port SCLK, output, 1 bit: serial shift clock to the LED drivers and the GS state machine.
REQ-013 SHALL have port LAT, output, 1 bit: word latch pulse.
REQ-014 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-015 SHALL have port frame_done, output, 1 bit: single-cycle pulse at the end of a frame.
REQ-016 SHALL have port overrun, output, 1 bit: sticky flag; an angle change arrived mid-frame.

Function
REQ-017 SHALL detect new_angle when angle differs from its value registered on the previous cycle.
REQ-018 SHALL implement the states IDLE, SHIFT_HI, SHIFT_LO, LATCH and DONE.
REQ-019 SHALL, in IDLE with new_angle=1 and FC_en=0, enter SHIFT_HI on the next cycle.
REQ-020 SHALL, with SCLK a registered output, drive SCLK=1 in SHIFT_HI and SCLK=0 in every other state.
REQ-021 SHALL hold SHIFT_HI and SHIFT_LO for exactly SCLK_HALF cycles each; one HI+LO pair is one SCLK pulse.
REQ-022 SHALL, after 3*NB_LEDS_PER_GROUP pulses (one word; 48 at default parameters), go from SHIFT_LO to LATCH.
REQ-023 SHALL drive LAT=1 for exactly LAT_CYCLES cycles in LATCH, with SCLK=0 throughout.
REQ-024 SHALL count words 0..NB_BITS*NB_ROWS-1; after LATCH, go to SHIFT_HI if words remain, otherwise to DONE.
REQ-025 SHALL spend one cycle in DONE with frame_done=1, then return to IDLE.
REQ-026 SHALL hold busy=1 in SHIFT_HI, SHIFT_LO and LATCH, and busy=0 in IDLE and DONE.
REQ-027 SHALL make a frame at default parameters 40 words = 1920 SCLK pulses = 40*(48*4+2) = 7760 busy cycles.
REQ-028 SHALL, on new_angle while busy=1: set overrun=1, clear all counters, and enter SHIFT_HI next cycle (restart); no LAT or frame_done for the aborted frame.
REQ-029 SHALL, while FC_en=1 in any state: go to IDLE next cycle, clear counters, drive SCLK=0 and LAT=0, and not set overrun.
REQ-030 SHALL ignore new_angle while FC_en=1; after FC_en falls, wait for the next angle change.
REQ-031 SHALL, with new_angle and FC_en both high, give FC_en priority.
REQ-032 SHALL, with ovr_clr and an overrun event in the same cycle, give set priority (overrun stays 1).
REQ-033 SHALL, on new_angle in DONE, pulse frame_done and enter SHIFT_HI next cycle with no overrun.
REQ-034 SHALL use counter widths of $clog2 of each terminal count, and terminal compares with no wrap-around.

Reset
REQ-035 SHALL on rst=1 force state IDLE, all counters 0, SCLK=0, LAT=0, busy=0, frame_done=0, overrun=0.
REQ-036 SHALL, on rst=1 mid-frame, abort with no LAT pulse and no frame_done.
REQ-037 SHALL load the registered previous angle from angle during reset, so the first cycle after reset gives no spurious new_angle.

Structure
REQ-038 SHALL take the state enum and the default geometry constants (NB_BITS, NB_ROWS, words per frame) from shared package litspin_gs_pkg.
REQ-039 SHALL contain one sub-module, sclk_phase_timer: a loadable down-counter that issues a phase-expiry strobe, reused for SHIFT_HI, SHIFT_LO and LATCH durations.

Verification
REQ-040 SHALL cover: angle 0->1 after reset, default params -> 1920 SCLK pulses, 40 LAT pulses each 2 cycles wide, frame_done exactly 7761 cycles after the angle change, overrun=0.
REQ-041 SHALL cover: angle change at word 10 of a frame -> overrun=1; restart with a full 1920 pulses; only one frame_done.
REQ-042 SHALL cover: FC_en high for 5 cycles mid-word -> SCLK=0 and busy=0 within 1 cycle; no frame_done; angle changes during FC_en give no frame.
REQ-043 SHALL cover: rst asserted in LATCH -> all outputs 0 next cycle; no spurious frame start after rst falls with angle unchanged.
REQ-044 SHALL cover: ovr_clr and an overrun event in the same cycle -> overrun=1; ovr_clr alone the next cycle -> overrun=0.
REQ-045 SHALL cover: SCLK_HALF=1, LAT_CYCLES=1, NB_ROWS=1 -> 10 words, 480 pulses, 10*(48*2+1)=970 busy cycles.
